// File: rtl/qed_pkg.sv
// Shared opcode constants, FSM state and decode classes for the QED duplication queue.
package qed_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic {ORIG, DUP} state_e;

    typedef enum logic [2:0] {CL_R, CL_I, CL_LD, CL_ST, CL_U, CL_OTHER} class_e;

    // Duplicates live in the upper half of the register file; x0 stays x0.
    function automatic logic [4:0] remap_reg(input logic [4:0] r);
        return (r == 5'd0) ? 5'd0 : {1'b1, r[3:0]};
    endfunction

endpackage

// File: rtl/qed_instr_remap.sv
// Combinational RV32I class decode plus register/memory partition remap of one instruction.
module qed_instr_remap
    import qed_pkg::*;
#(
    parameter int MEM_KEEP_BITS = 6
) (
    input  logic [31:0] instr_i,
    output class_e      cls_o,
    output logic [31:0] dup_o
);

    localparam logic [11:0] KEEP_MASK = 12'((1 << MEM_KEEP_BITS) - 1);
    localparam logic [11:0] KEEP_SET  = 12'(1 << MEM_KEEP_BITS);

    logic [4:0]  rd_m, rs1_m, rs2_m;
    logic [11:0] off_ld, off_st;

    assign rd_m   = remap_reg(instr_i[11:7]);
    assign rs1_m  = remap_reg(instr_i[19:15]);
    assign rs2_m  = remap_reg(instr_i[24:20]);
    // Offsets are squeezed into the duplicate memory window above the kept low bits.
    assign off_ld = (instr_i[31:20] & KEEP_MASK) | KEEP_SET;
    assign off_st = ({instr_i[31:25], instr_i[11:7]} & KEEP_MASK) | KEEP_SET;

    always_comb begin
        cls_o = CL_OTHER;
        dup_o = instr_i;
        case (instr_i[6:0])
            OP_R: begin
                cls_o = CL_R;
                dup_o = {instr_i[31:25], rs2_m, rs1_m, instr_i[14:12], rd_m, instr_i[6:0]};
            end
            OP_I: begin
                cls_o = CL_I;
                dup_o = {instr_i[31:20], rs1_m, instr_i[14:12], rd_m, instr_i[6:0]};
            end
            OP_LD: begin
                cls_o = CL_LD;
                dup_o = {off_ld, rs1_m, instr_i[14:12], rd_m, instr_i[6:0]};
            end
            OP_ST: begin
                cls_o = CL_ST;
                dup_o = {off_st[11:5], rs2_m, rs1_m, instr_i[14:12], off_st[4:0], instr_i[6:0]};
            end
            OP_LUI, OP_AUIPC: begin
                cls_o = CL_U;
                dup_o = {instr_i[31:12], rd_m, instr_i[6:0]};
            end
            default: begin
                cls_o = CL_OTHER;
                dup_o = instr_i;
            end
        endcase
    end

endmodule

// File: rtl/qed_dup_queue.sv
// QED duplication queue: passes originals through, buffers remapped duplicates, drains them on full or exec_dup.
module qed_dup_queue
    import qed_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int MEM_KEEP_BITS = 6,
    parameter int CNT_W         = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             exec_dup,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instruction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instruction,
    output logic             out_is_dup,
    output logic [CNT_W-1:0] fifo_count,
    output logic             qed_ready
);

    localparam int AW = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [31:0]       mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d, cnt_post;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic              out_dup_q, out_dup_d;
    logic              load, full, empty, accept, push, pop;
    class_e            in_cls;
    logic [31:0]       in_dup;

    // Duplicates are remapped on the way in, so the FIFO head is already output-ready.
    qed_instr_remap #(.MEM_KEEP_BITS(MEM_KEEP_BITS)) u_remap (
        .instr_i (in_instruction),
        .cls_o   (in_cls),
        .dup_o   (in_dup)
    );

    assign load  = !out_valid_q || out_ready;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        accept      = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_dup_d   = out_dup_q;
        cnt_post    = count_q;
        case (state_q)
            ORIG: begin
                in_ready = load && (!ena || !full);
                accept   = in_valid && in_ready;
                push     = accept && ena && (in_cls != CL_OTHER);
                if (load) begin
                    out_valid_d = accept;
                    if (accept) begin
                        out_instr_d = in_instruction;
                        out_dup_d   = 1'b0;
                    end
                end
                cnt_post = count_q + CNT_W'(push);
                if ((push && cnt_post == CNT_W'(DEPTH)) || (exec_dup && cnt_post != '0))
                    state_d = DUP;
            end
            DUP: begin
                if (load) begin
                    pop         = !empty;
                    out_valid_d = pop;
                    if (pop) begin
                        out_instr_d = mem_q[rd_ptr_q];
                        out_dup_d   = 1'b1;
                    end
                end
                if (empty || (pop && count_q == CNT_W'(1)))
                    state_d = ORIG;
            end
            default: state_d = ORIG;
        endcase
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ORIG;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_dup_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_dup_q   <= out_dup_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_dup;
    end

    assign out_valid       = out_valid_q;
    assign out_instruction = out_instr_q;
    assign out_is_dup      = out_dup_q;
    assign fifo_count      = count_q;
    assign qed_ready       = (state_q == ORIG) && empty && !(out_valid_q && out_dup_q);

endmodule

// File: tb/tb_qed_dup_queue.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_qed_dup_queue;

    localparam int DEPTH = 8;
    localparam int KEEP  = 6;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n, ena, exec_dup, in_valid, out_ready;
    logic [31:0]      in_instruction;
    logic             in_ready, out_valid, out_is_dup, qed_ready;
    logic [31:0]      out_instruction;
    logic [CNT_W-1:0] fifo_count;

    int nvec = 0;
    int nerr = 0;

    // reference model state
    int unsigned mq[$];
    bit          mdup, mov, mod;
    logic [31:0] moi;

    always #5 clk = ~clk;

    qed_dup_queue #(.DEPTH(DEPTH), .MEM_KEEP_BITS(KEEP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .exec_dup(exec_dup),
        .in_valid(in_valid), .in_ready(in_ready), .in_instruction(in_instruction),
        .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
        .out_is_dup(out_is_dup), .fifo_count(fifo_count), .qed_ready(qed_ready)
    );

    function automatic int unsigned rmreg(input int unsigned r);
        return (r == 0) ? 0 : 16 + (r % 16);
    endfunction

    function automatic int unsigned setf(input int unsigned y, input int pos, input int w,
                                         input int unsigned v);
        int unsigned m;
        m = ((32'd1 << w) - 1) << pos;
        return (y & ~m) | ((v << pos) & m);
    endfunction

    function automatic bit dupable(input int unsigned x);
        int unsigned op;
        op = x % 128;
        return op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 ||
               op == 7'h37 || op == 7'h17;
    endfunction

    function automatic int unsigned m_remap(input int unsigned x);
        int unsigned op, rd, rs1, rs2, off, y;
        op  = x % 128;
        rd  = (x >> 7) % 32;
        rs1 = (x >> 15) % 32;
        rs2 = (x >> 20) % 32;
        y   = x;
        if (op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h37 || op == 7'h17)
            y = setf(y, 7, 5, rmreg(rd));
        if (op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23)
            y = setf(y, 15, 5, rmreg(rs1));
        if (op == 7'h33 || op == 7'h23)
            y = setf(y, 20, 5, rmreg(rs2));
        if (op == 7'h03) begin
            off = (1 << KEEP) + ((x >> 20) % (1 << KEEP));
            y   = setf(y, 20, 12, off);
        end
        if (op == 7'h23) begin
            off = (1 << KEEP) + ((((x >> 25) * 32) + rd) % (1 << KEEP));
            y   = setf(y, 7, 5, off % 32);
            y   = setf(y, 25, 7, off / 32);
        end
        return y;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: apply inputs, compare DUT with model, advance model at the edge.
    task automatic step(input bit r, input bit e, input bit x, input bit v,
                        input logic [31:0] ins, input bit ordy);
        bit mload, exp_ir, acc;
        rst_n = r; ena = e; exec_dup = x; in_valid = v; in_instruction = ins; out_ready = ordy;
        #1;
        mload  = !mov || ordy;
        exp_ir = !mdup && mload && (!e || mq.size() < DEPTH);
        chk("in_ready",   32'(in_ready),   32'(exp_ir));
        chk("out_valid",  32'(out_valid),  32'(mov));
        if (mov) begin
            chk("out_instruction", out_instruction, moi);
            chk("out_is_dup", 32'(out_is_dup), 32'(mod));
        end
        chk("fifo_count", 32'(fifo_count), mq.size());
        chk("qed_ready",  32'(qed_ready),  32'(!mdup && mq.size() == 0 && !(mov && mod)));
        @(posedge clk);
        if (!r) begin
            mq.delete(); mdup = 0; mov = 0; mod = 0; moi = '0;
        end else if (mdup) begin
            if (mload) begin
                moi = mq.pop_front(); mov = 1; mod = 1;
                if (mq.size() == 0) mdup = 0;
            end
        end else begin
            acc = v && exp_ir;
            if (mload) begin
                mov = acc;
                if (acc) begin moi = ins; mod = 0; end
            end
            if (acc && e && dupable(ins)) begin
                mq.push_back(m_remap(ins));
                if (mq.size() == DEPTH) mdup = 1;
            end
            if (x && mq.size() > 0) mdup = 1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit e);
        for (int i = 0; i < n; i++) step(1, e, 0, 0, 32'h0, 1);
    endtask

    logic [31:0] ops [8] = '{32'h33, 32'h13, 32'h03, 32'h23, 32'h37, 32'h17, 32'h63, 32'h6F};

    initial begin
        logic [31:0] rv, pick;
        rst_n = 0; ena = 1; exec_dup = 0; in_valid = 0; in_instruction = '0; out_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mq.delete(); mdup = 0; mov = 0; mod = 0; moi = '0;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_qed_ready", 32'(qed_ready), 1);

        // model pinning against hand-derived encodings
        chk("model_add", m_remap(32'h003100B3), 32'h013908B3);
        chk("model_lw",  m_remap(32'h00802283), 32'h04802A83);
        chk("model_sw",  m_remap(32'h06312223), 32'h07392223);

        // pass-through then duplicates
        step(1, 1, 0, 1, 32'h003100B3, 1);
        chk("t1_orig0", out_instruction, 32'h003100B3);
        step(1, 1, 0, 1, 32'h00802283, 1);
        chk("t1_orig1", out_instruction, 32'h00802283);
        chk("t1_orig1_dup", 32'(out_is_dup), 0);
        step(1, 1, 1, 0, 32'h0, 1);
        chk("t1_cnt", 32'(fifo_count), 2);
        step(1, 1, 0, 0, 32'h0, 1);
        chk("t1_dup0", out_instruction, 32'h013908B3);
        chk("t1_dup0_flag", 32'(out_is_dup), 1);
        step(1, 1, 0, 0, 32'h0, 1);
        chk("t1_dup1", out_instruction, 32'h04802A83);
        chk("t1_qr_busy", 32'(qed_ready), 0);
        step(1, 1, 0, 0, 32'h0, 1);
        chk("t1_qr_done", 32'(qed_ready), 1);

        // FIFO full: 8 addi without exec_dup
        for (int i = 0; i < 8; i++) step(1, 1, 0, 1, 32'h00000093 | (32'(i + 1) << 20), 1);
        chk("t2_full", 32'(fifo_count), 8);
        step(1, 1, 0, 1, 32'h00100093, 1);
        idle(8, 1);
        chk("t2_empty", 32'(fifo_count), 0);
        chk("t2_in_ready", 32'(in_ready), 1);

        // backpressure mid-drain
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 32'h002081B3 + (32'(i) << 7), 1);
        step(1, 1, 1, 0, 32'h0, 1);
        step(1, 1, 0, 0, 32'h0, 1);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 32'h0, 0);
        chk("t3_hold_cnt", 32'(fifo_count), 3);
        idle(5, 1);

        // OTHER instruction is not enqueued
        step(1, 1, 0, 1, 32'h003100B3, 1);
        step(1, 1, 0, 1, 32'h00208463, 1);
        chk("t4_beq_pass", out_instruction, 32'h00208463);
        chk("t4_cnt", 32'(fifo_count), 1);
        step(1, 1, 1, 0, 32'h0, 1);
        step(1, 1, 0, 0, 32'h0, 1);
        chk("t4_dup", out_instruction, 32'h013908B3);
        idle(2, 1);

        // ena dropped during a drain
        for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 32'h00500113 + (32'(i) << 15), 1);
        step(1, 1, 1, 0, 32'h0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 32'hDEAD0033, 1);
        chk("t5_drained", 32'(fifo_count), 0);
        step(1, 0, 0, 1, 32'h003100B3, 1);
        chk("t5_pass", out_instruction, 32'h003100B3);
        chk("t5_nopush", 32'(fifo_count), 0);
        idle(1, 1);

        // reset mid-drain
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 32'h00802283, 1);
        step(1, 1, 1, 0, 32'h0, 1);
        step(1, 1, 0, 0, 32'h0, 1);
        step(0, 1, 0, 0, 32'h0, 1);
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_cnt", 32'(fifo_count), 0);
        chk("t6_qr", 32'(qed_ready), 1);
        chk("t6_orig", 32'(in_ready), 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rv   = $urandom();
            pick = ops[$urandom_range(0, 7)];
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                 {rv[31:7], pick[6:0]}, ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
